// File: rtl/score_disp_pkg.sv
// Shared types, segment patterns and sizing helpers for the score display driver.
package score_disp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      ENCODE = 2'd2
   } state_t;

   // Bit order per digit: g,f,e,d,c,b,a (bit6..bit0), active-high.
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
      7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1100111
   };

   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

   // ceil(bin_w * log10(2)); the product is never an exact integer for bin_w >= 1.
   function automatic int bcd_digits(input int bin_w);
      return (bin_w * 30103 + 99999) / 100000;
   endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// One BCD nibble to a seven-segment pattern; non-decimal nibbles and blanked digits go dark.
module seg7_digit_enc
   import score_disp_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank && nibble <= 4'd9) seg = SEG_DIGIT[nibble];
   end

endmodule

// File: rtl/score_bcd_display.sv
// Serial double-dabble score converter feeding NUM_DIGITS seven-segment digits,
// with leading-zero blanking and all-nines saturation on overflow.
module score_bcd_display
   import score_disp_pkg::*;
#(
   parameter int BIN_W      = 16,
   parameter int NUM_DIGITS = 5,
   parameter int BLANK_LZ   = 1
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic                    load,
   input  logic [BIN_W-1:0]        value,
   output logic                    busy,
   output logic                    done,
   output logic                    ovf,
   output logic [7*NUM_DIGITS-1:0] segs
);

   localparam int          NDI_RAW = bcd_digits(BIN_W);
   localparam int          NDI     = (NDI_RAW > NUM_DIGITS) ? NDI_RAW : NUM_DIGITS;
   localparam int          BCD_W   = 4 * NDI;
   localparam int          CNT_W   = $clog2(BIN_W + 1);
   localparam logic [63:0] MAXV    = pow10(NUM_DIGITS) - 64'd1;

   function automatic logic exceeds_max(input logic [BIN_W-1:0] v);
      return {{(64-BIN_W){1'b0}}, v} > MAXV;
   endfunction

   // Saturated display forces every digit to 9.
   function automatic logic [3:0] sat_nibble(input logic [3:0] nib, input logic sat);
      return sat ? 4'd9 : nib;
   endfunction

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [BIN_W-1:0]   shreg;
   logic [BCD_W-1:0]   bcd;
   logic               ovf_lat;

   logic [BCD_W-1:0]       bcd_adj;
   logic [BCD_W+BIN_W-1:0] cat_sh;
   logic [BCD_W-1:0]       bcd_next;
   logic [BIN_W-1:0]       sh_next;

   // Add-3 correction on every nibble, then one combined left shift.
   always_comb begin
      bcd_adj = bcd;
      for (int k = 0; k < NDI; k++) begin
         if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
      cat_sh   = {bcd_adj, shreg} << 1;
      bcd_next = cat_sh[BIN_W +: BCD_W];
      sh_next  = cat_sh[BIN_W-1:0];
   end

   logic [NUM_DIGITS-1:0]   blank;
   logic [3:0]              enc_nib [NUM_DIGITS];
   logic [7*NUM_DIGITS-1:0] enc_seg;

   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      blank      = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         blank[k]   = (BLANK_LZ != 0) && !ovf_lat && zero_above && (bcd[4*k +: 4] == 4'd0);
         zero_above = zero_above && (bcd[4*k +: 4] == 4'd0);
      end
      for (int k = 0; k < NUM_DIGITS; k++) enc_nib[k] = sat_nibble(bcd[4*k +: 4], ovf_lat);
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      seg7_digit_enc u_enc (
         .nibble (enc_nib[g]),
         .blank  (blank[g]),
         .seg    (enc_seg[7*g +: 7])
      );
   end

   // The done cycle is spent in IDLE, so a load there is held off until the next cycle.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state   <= IDLE;
         cnt     <= '0;
         shreg   <= '0;
         bcd     <= '0;
         ovf_lat <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ovf     <= 1'b0;
         segs    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load && !done) begin
                  shreg   <= value;
                  bcd     <= '0;
                  ovf_lat <= exceeds_max(value);
                  cnt     <= CNT_W'(BIN_W);
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               bcd   <= bcd_next;
               shreg <= sh_next;
               cnt   <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) state <= ENCODE;
            end
            ENCODE: begin
               segs  <= enc_seg;
               ovf   <= ovf_lat;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
